prog_loader: RTL and testbench

Byte-stream program loader that fills instruction memory before the 16-bit RISC core runs. It accepts a framed byte stream over a valid/ready handshake, assembles 16-bit big-endian words, and writes them into the instruction RAM's write port (`ram_we`, address, write data). It holds the core in reset until a load completes with a good checksum. It is the writer side of the RAM that the PC unit and fetch path read from.

---
 rtl/prog_loader.sv | 162 ++++++++++++++++
 tb/tb_prog_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses a length/data/checksum frame and writes
// 16-bit big-endian words into instruction RAM, holding the core in reset until success.
module prog_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_data,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CSUM, DONE, ERR
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state, state_nxt;
    logic [15:0] word_count, word_count_nxt;
    logic [15:0] word_index, word_index_nxt;
    logic [15:0] index_inc;
    logic [15:0] len_word;
    logic [7:0]  csum, csum_nxt;
    logic        xfer;
    logic        in_ready_nxt, ram_we_nxt, cpu_rst_nxt, busy_nxt, done_nxt, err_nxt;
    logic [15:0] ram_addr_nxt, ram_data_nxt;

    assign xfer      = in_valid & in_ready;
    assign index_inc = word_index + 16'd1;
    assign len_word  = {word_count[15:8], in_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            word_count <= '0;
            word_index <= '0;
            csum       <= '0;
            in_ready   <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
            cpu_rst    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            word_count <= word_count_nxt;
            word_index <= word_index_nxt;
            csum       <= csum_nxt;
            in_ready   <= in_ready_nxt;
            ram_we     <= ram_we_nxt;
            ram_addr   <= ram_addr_nxt;
            ram_data   <= ram_data_nxt;
            cpu_rst    <= cpu_rst_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
        end
    end

    // Every output is computed one cycle ahead so it can be registered directly.
    always_comb begin
        state_nxt      = state;
        word_count_nxt = word_count;
        word_index_nxt = word_index;
        csum_nxt       = csum;
        ram_we_nxt     = 1'b0;
        ram_addr_nxt   = ram_addr;
        ram_data_nxt   = ram_data;
        cpu_rst_nxt    = cpu_rst;
        busy_nxt       = busy;
        done_nxt       = done;
        err_nxt        = err;

        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nxt      = LEN_HI;
                    busy_nxt       = 1'b1;
                    cpu_rst_nxt    = 1'b1;
                    done_nxt       = 1'b0;
                    err_nxt        = 1'b0;
                    word_index_nxt = '0;
                    csum_nxt       = '0;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    word_count_nxt[15:8] = in_data;
                    csum_nxt             = csum ^ in_data;
                    state_nxt            = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    word_count_nxt = len_word;
                    csum_nxt       = csum ^ in_data;
                    if ({1'b0, len_word} > MAX_W) begin
                        state_nxt = ERR;
                        err_nxt   = 1'b1;
                        busy_nxt  = 1'b0;
                    end else if (len_word == 16'd0) begin
                        state_nxt = CSUM;
                    end else begin
                        state_nxt = DAT_HI;
                    end
                end
            end
            DAT_HI: begin
                if (xfer) begin
                    ram_data_nxt[15:8] = in_data;
                    csum_nxt           = csum ^ in_data;
                    state_nxt          = DAT_LO;
                end
            end
            DAT_LO: begin
                if (xfer) begin
                    ram_data_nxt[7:0] = in_data;
                    csum_nxt          = csum ^ in_data;
                    ram_we_nxt        = 1'b1;
                    ram_addr_nxt      = BASE_ADDR + word_index;
                    state_nxt         = WRITE;
                end
            end
            WRITE: begin
                word_index_nxt = index_inc;
                state_nxt      = (index_inc == word_count) ? CSUM : DAT_HI;
            end
            CSUM: begin
                if (xfer) begin
                    busy_nxt = 1'b0;
                    if (in_data == csum) begin
                        state_nxt   = DONE;
                        done_nxt    = 1'b1;
                        cpu_rst_nxt = 1'b0;
                    end else begin
                        state_nxt = ERR;
                        err_nxt   = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // WRITE deliberately drops ready, giving the one-cycle stall per word.
        in_ready_nxt = (state_nxt == LEN_HI) || (state_nxt == LEN_LO) ||
                       (state_nxt == DAT_HI) || (state_nxt == DAT_LO) ||
                       (state_nxt == CSUM);
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: two instances (base 0x0000 and 0xFFFF) share
// the same byte stream and are compared against a frame-level reference model.
module tb_prog_loader;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        in_ready0, ram_we0, cpu_rst0, busy0, done0, err0;
    logic [15:0] ram_addr0, ram_data0;
    logic        in_ready1, ram_we1, cpu_rst1, busy1, done1, err1;
    logic [15:0] ram_addr1, ram_data1;

    int total = 0;
    int bad   = 0;
    int xfers0 = 0;
    int xfers1 = 0;
    wr_t got0[$];
    wr_t got1[$];
    logic [7:0] frame[$];

    always #5 clk = ~clk;

    prog_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(256)) dut0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .ram_we(ram_we0), .ram_addr(ram_addr0), .ram_data(ram_data0),
        .cpu_rst(cpu_rst0), .busy(busy0), .done(done0), .err(err0)
    );

    prog_loader #(.BASE_ADDR(16'hFFFF), .MAX_WORDS(256)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_data(ram_data1),
        .cpu_rst(cpu_rst1), .busy(busy1), .done(done1), .err(err1)
    );

    // Transfers are counted at the edge where they happen.
    always @(posedge clk) begin
        if (in_valid && in_ready0) xfers0 <= xfers0 + 1;
        if (in_valid && in_ready1) xfers1 <= xfers1 + 1;
    end

    always @(negedge clk) begin
        if (ram_we0) got0.push_back({ram_addr0, ram_data0});
        if (ram_we1) got1.push_back({ram_addr1, ram_data1});
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic loadHex(input logic [63:0] v, input int len);
        frame = {};
        for (int i = 0; i < len; i++) frame.push_back(v[8*(len-1-i) +: 8]);
    endtask

    task automatic buildFrame(input int n, input bit corrupt);
        logic [7:0] x;
        frame = {};
        frame.push_back(8'(n >> 8));
        frame.push_back(8'(n));
        for (int i = 0; i < 2 * n; i++) frame.push_back(8'($urandom));
        x = 8'h00;
        foreach (frame[i]) x ^= frame[i];
        frame.push_back(corrupt ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
    endtask

    // Called at a negedge; returns at the negedge after the last transfer edge.
    task automatic applyStimulus(input int need, input bit randValid, output int cyc);
        int idx;
        bit v;
        idx = 0;
        cyc = 0;
        while (idx < need && cyc < 5000) begin
            v = randValid ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_valid = v;
            in_data  = v ? frame[idx] : 8'($urandom);
            if (randValid) start = ($urandom_range(0, 7) == 0);
            if (v && in_ready0) idx++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic pulseStart(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkVal({tag, ".ready_after_start"}, {in_ready1, in_ready0}, 2'b11);
        checkVal({tag, ".busy_after_start"}, {busy1, busy0}, 2'b11);
        checkVal({tag, ".flags_after_start"}, {cpu_rst0, done0, err0}, 3'b100);
    endtask

    task automatic checkOutput(input string tag, input bit ok, input int need,
                               input wr_t e0[$], input wr_t e1[$]);
        checkVal({tag, ".done"}, {done1, done0}, ok ? 2'b11 : 2'b00);
        checkVal({tag, ".err"}, {err1, err0}, ok ? 2'b00 : 2'b11);
        checkVal({tag, ".cpu_rst"}, {cpu_rst1, cpu_rst0}, ok ? 2'b00 : 2'b11);
        checkVal({tag, ".busy"}, {busy1, busy0}, 2'b00);
        checkVal({tag, ".xfers0"}, xfers0, need);
        checkVal({tag, ".xfers1"}, xfers1, need);
        checkVal({tag, ".nwrites0"}, got0.size(), e0.size());
        checkVal({tag, ".nwrites1"}, got1.size(), e1.size());
        for (int i = 0; i < e0.size() && i < got0.size(); i++)
            checkVal($sformatf("%s.wr0[%0d]", tag, i), got0[i], e0[i]);
        for (int i = 0; i < e1.size() && i < got1.size(); i++)
            checkVal($sformatf("%s.wr1[%0d]", tag, i), got1[i], e1[i]);
    endtask

    // Reference model works on the whole frame: expected writes, result and byte count.
    task automatic runFrame(input bit randValid, input string tag);
        int n, need, cyc;
        bit ok;
        logic [7:0] x;
        wr_t e0[$];
        wr_t e1[$];
        n = {frame[0], frame[1]};
        if (n > 256) begin
            need = 2;
            ok   = 1'b0;
        end else begin
            need = 3 + 2 * n;
            x = 8'h00;
            for (int i = 0; i < 2 + 2 * n; i++) x ^= frame[i];
            ok = (frame[2 + 2 * n] == x);
            for (int w = 0; w < n; w++) begin
                e0.push_back({16'(w), frame[2 + 2 * w], frame[3 + 2 * w]});
                e1.push_back({16'hFFFF + 16'(w), frame[2 + 2 * w], frame[3 + 2 * w]});
            end
        end
        got0 = {};
        got1 = {};
        xfers0 = 0;
        xfers1 = 0;
        pulseStart(tag);
        applyStimulus(need, randValid, cyc);
        checkVal({tag, ".in_time"}, cyc < 5000, 1);
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        checkOutput(tag, ok, need, e0, e1);
        repeat (3) begin
            @(negedge clk);
            checkVal({tag, ".no_accept_after"}, {in_ready1, in_ready0}, 2'b00);
        end
        in_valid = 1'b0;
        checkVal({tag, ".xfers_after_idle"}, xfers0, need);
        checkVal({tag, ".done_stable"}, done0, ok);
    endtask

    initial begin
        int cyc;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #12;
        checkVal("reset.ctrl0", {in_ready0, ram_we0, cpu_rst0, busy0, done0, err0}, 6'b001000);
        checkVal("reset.ctrl1", {in_ready1, ram_we1, cpu_rst1, busy1, done1, err1}, 6'b001000);
        checkVal("reset.bus0", {ram_addr0, ram_data0}, 32'h0);
        checkVal("reset.bus1", {ram_addr1, ram_data1}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        checkVal("idle.no_ready", {in_ready1, in_ready0}, 2'b00);
        checkVal("idle.no_xfer", xfers0, 0);
        in_valid = 1'b0;

        loadHex(64'h0002_1234_ABCD_42, 7);
        runFrame(1'b0, "nominal");
        loadHex(64'h0002_1234_ABCD_43, 7);
        runFrame(1'b0, "badcsum");
        loadHex(64'h000000, 3);
        runFrame(1'b0, "empty");
        loadHex(64'h0101_0000_00, 5);
        runFrame(1'b0, "oversize");
        loadHex(64'h0002_1234_ABCD_42, 7);
        runFrame(1'b1, "backpressure");
        loadHex(64'h0002_0001_0002_01, 7);
        runFrame(1'b1, "wrapframe");

        // Reset asserted during the first WRITE cycle of a frame.
        loadHex(64'h0002_1234_ABCD_42, 7);
        got0 = {};
        got1 = {};
        pulseStart("midreset");
        applyStimulus(4, 1'b0, cyc);
        checkVal("midreset.we_before", {ram_we1, ram_we0}, 2'b11);
        #1 rst = 1'b1;
        #1;
        checkVal("midreset.ctrl0", {in_ready0, ram_we0, cpu_rst0, busy0, done0, err0}, 6'b001000);
        checkVal("midreset.ctrl1", {in_ready1, ram_we1, cpu_rst1, busy1, done1, err1}, 6'b001000);
        checkVal("midreset.bus0", {ram_addr0, ram_data0}, 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkVal("midreset.nwrites", got0.size() + got1.size(), 2);
        if (got0.size() == 1) checkVal("midreset.wr0", got0[0], 32'h0000_1234);
        if (got1.size() == 1) checkVal("midreset.wr1", got1[0], 32'hFFFF_1234);
        loadHex(64'h0002_0001_0002_01, 7);
        runFrame(1'b0, "afterreset");

        buildFrame(256, 1'b0);
        runFrame(1'b1, "max256");
        for (int t = 0; t < 6; t++) begin
            buildFrame($urandom_range(1, 6), $urandom_range(0, 2) == 0);
            runFrame(1'b1, $sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
